// File: rtl/adder_cu_pkg.sv
// Shared constants for the sign-magnitude operand conditioning unit in front of the VPU adder.
package adder_cu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bit positions of the per-operand complement flags in the c vector
    localparam int CF_A = 1;
    localparam int CF_B = 0;

endpackage

// File: rtl/adder_cu_if.sv
// Operand/result bundle between the issue logic (master) and the conditioning unit (slave).
interface adder_cu_if import adder_cu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic [WIDTH:0]   A;
    logic [WIDTH:0]   B;
    logic             a;
    logic             out_valid;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;
    logic [1:0]       c;

    modport master (
        output in_valid, A, B, a,
        input  out_valid, A_out, B_out, c
    );

    modport slave (
        input  in_valid, A, B, a,
        output out_valid, A_out, B_out, c
    );

endinterface

// File: rtl/adder_cu_twos_comp_cond.sv
// Conditional two's-complement negation of an unsigned magnitude; the increment carry is dropped.
module twos_comp_cond import adder_cu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] mag,
    input  logic             en,
    output logic [WIDTH-1:0] result
);

    assign result = en ? (~mag + WIDTH'(1)) : mag;

endmodule

// File: rtl/adder_cu.sv
// Turns sign-magnitude A and B plus add/sub opcode into two's-complement operands and complement flags, registered.
module adder_cu import adder_cu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    adder_cu_if.slave    bus
);

    logic [1:0]       c_next;
    logic [WIDTH-1:0] a_out_next;
    logic [WIDTH-1:0] b_out_next;

    // Subtraction is folded into B's effective sign, so the adder only ever adds
    assign c_next[CF_A] = bus.A[WIDTH];
    assign c_next[CF_B] = bus.B[WIDTH] ^ (bus.a == OP_SUB);

    twos_comp_cond #(.WIDTH(WIDTH)) u_cond_a (
        .mag    (bus.A[WIDTH-1:0]),
        .en     (c_next[CF_A]),
        .result (a_out_next)
    );

    twos_comp_cond #(.WIDTH(WIDTH)) u_cond_b (
        .mag    (bus.B[WIDTH-1:0]),
        .en     (c_next[CF_B]),
        .result (b_out_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.A_out     <= '0;
            bus.B_out     <= '0;
            bus.c         <= 2'b00;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.A_out <= a_out_next;
                bus.B_out <= b_out_next;
                bus.c     <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_adder_cu.sv
// Directed-vector bench for adder_cu: sign/op sweep, boundaries, reset, streaming and hold.
module tb_adder_cu;
    import adder_cu_pkg::*;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   check_count = 0;
    int   pass_count  = 0;
    int   fail_count  = 0;

    adder_cu_if #(.WIDTH(WIDTH)) bus ();

    adder_cu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic a_sign, input logic [31:0] a_mag,
                                 input logic b_sign, input logic [31:0] b_mag, input logic op);
        @(negedge clk);
        bus.in_valid = valid;
        bus.A        = {a_sign, a_mag};
        bus.B        = {b_sign, b_mag};
        bus.a        = op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic exp_valid, input logic [31:0] exp_a,
                            input logic [31:0] exp_b, input logic [1:0] exp_c);
        checkOutput({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_valid});
        checkOutput({tag, ".A_out"}, bus.A_out, exp_a);
        checkOutput({tag, ".B_out"}, bus.B_out, exp_b);
        checkOutput({tag, ".c"}, {30'd0, bus.c}, {30'd0, exp_c});
    endtask

    initial begin
        logic [1:0]  sweep_c [8];
        logic [31:0] sweep_a [8];
        logic [31:0] sweep_b [8];

        // Hand-computed results for {A sign, B sign, op} = 0..7 with |A|=5, |B|=3
        sweep_c = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10};
        sweep_a = '{32'h5, 32'h5, 32'h5, 32'h5,
                    32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        sweep_b = '{32'h3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h3,
                    32'h3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h3};

        // Reset asserted together with a valid input drops that input
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.A        = {1'b1, 32'h0000_1234};
        bus.B        = {1'b1, 32'h0000_0042};
        bus.a        = OP_ADD;
        tick();
        checkAll("reset_with_valid", 1'b0, 32'h0, 32'h0, 2'b00);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, OP_ADD);
        rst = 1'b0;
        tick();
        checkAll("idle_after_reset", 1'b0, 32'h0, 32'h0, 2'b00);
        tick();
        checkAll("idle_after_reset2", 1'b0, 32'h0, 32'h0, 2'b00);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] sel;
            sel = 3'(i);
            applyStimulus(1'b1, sel[2], 32'd5, sel[1], 32'd3, sel[0]);
            tick();
            checkAll($sformatf("sweep_%0d", i), 1'b1, sweep_a[i], sweep_b[i], sweep_c[i]);
        end

        applyStimulus(1'b1, 1'b0, 32'h10, 1'b0, 32'h20, OP_ADD);
        tick();
        checkAll("plain_add", 1'b1, 32'h10, 32'h20, 2'b00);

        applyStimulus(1'b1, 1'b0, 32'h7, 1'b0, 32'h7, OP_SUB);
        tick();
        checkAll("sub_pos", 1'b1, 32'h7, 32'hFFFF_FFF9, 2'b01);

        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 32'h1, OP_ADD);
        tick();
        checkAll("neg_zero", 1'b1, 32'h0, 32'h1, 2'b10);

        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h1, OP_ADD);
        tick();
        checkAll("neg_half", 1'b1, 32'h8000_0000, 32'h1, 2'b10);

        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h1, OP_ADD);
        tick();
        checkAll("neg_ones", 1'b1, 32'h1, 32'h1, 2'b10);

        // Gap, then three back-to-back operations followed by a hold
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, OP_ADD);
        tick();
        checkAll("gap_hold", 1'b0, 32'h1, 32'h1, 2'b10);

        applyStimulus(1'b1, 1'b0, 32'h1, 1'b0, 32'h2, OP_ADD);
        tick();
        checkAll("stream_0", 1'b1, 32'h1, 32'h2, 2'b00);
        applyStimulus(1'b1, 1'b1, 32'h2, 1'b0, 32'h3, OP_SUB);
        tick();
        checkAll("stream_1", 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 2'b11);
        applyStimulus(1'b1, 1'b0, 32'h1234, 1'b1, 32'h10, OP_ADD);
        tick();
        checkAll("stream_2", 1'b1, 32'h1234, 32'hFFFF_FFF0, 2'b01);

        applyStimulus(1'b0, 1'b1, 32'hDEAD, 1'b1, 32'hBEEF, OP_SUB);
        tick();
        checkAll("hold_0", 1'b0, 32'h1234, 32'hFFFF_FFF0, 2'b01);
        tick();
        checkAll("hold_1", 1'b0, 32'h1234, 32'hFFFF_FFF0, 2'b01);

        // Reset mid-stream discards the in-flight operation
        applyStimulus(1'b1, 1'b1, 32'h9, 1'b1, 32'h4, OP_ADD);
        tick();
        checkAll("pre_reset", 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 2'b11);
        applyStimulus(1'b1, 1'b0, 32'h55, 1'b0, 32'h66, OP_ADD);
        rst = 1'b1;
        tick();
        checkAll("mid_reset", 1'b0, 32'h0, 32'h0, 2'b00);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, OP_ADD);
        rst = 1'b0;
        tick();
        checkAll("post_reset", 1'b0, 32'h0, 32'h0, 2'b00);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/adder_cu.md
Name: adder_cu

Overview:
Sign-magnitude operand conditioning unit that sits in front of the VPU integer adder.
- Takes two sign-magnitude operands and an add/subtract opcode.
- Decides which operands must be negated, and presents both as two's-complement magnitudes plus per-operand complement flags, so a plain binary adder can follow.
- Outputs are registered: one-cycle latency.

Parameters:
- WIDTH, 32, magnitude width; each operand is WIDTH+1 bits with the sign in the MSB.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies A, B, a this cycle
- A  input  WIDTH+1  operand A; A[WIDTH] = sign (1 = negative), A[WIDTH-1:0] = magnitude
- B  input  WIDTH+1  operand B; same format as A
- a  input  1  operation: 0 = add (A+B), 1 = subtract (A-B)
- out_valid  output  1  A_out, B_out, c are valid
- A_out  output  WIDTH  conditioned operand A
- B_out  output  WIDTH  conditioned operand B
- c  output  2  complement flags: c[1] = A complemented, c[0] = B complemented

Behaviour:
- Combinational decision, per input cycle:
  - effective sign of A: As = A[WIDTH]
  - effective sign of B: Bs_eff = B[WIDTH] XOR a (subtract flips B's sign)
  - c_next[1] = As; c_next[0] = Bs_eff
- Conditional negation:
  - A_out_next = c_next[1] ? (~A[WIDTH-1:0] + 1) mod 2^WIDTH : A[WIDTH-1:0]
  - B_out_next = c_next[0] ? (~B[WIDTH-1:0] + 1) mod 2^WIDTH : B[WIDTH-1:0]
  - carry out of the increment is discarded.
- Truth table for {A[WIDTH], B[WIDTH], a} -> {c[1], c[0]}:
  - 000->00, 001->01, 010->01, 011->00
  - 100->10, 101->11, 110->11, 111->10
- Register stage:
  - On each rising clk with rst=0: out_valid <= in_valid.
  - When in_valid=1: A_out, B_out, c load their next values.
  - When in_valid=0: A_out, B_out, c hold their previous values.
- Latency: exactly 1 cycle from in_valid to out_valid. Throughput is 1 operation per cycle, with no backpressure.
- Reset: when rst=1 at a rising edge, out_valid=0, A_out=0, B_out=0, c=2'b00.
  - Reset overrides a simultaneous in_valid; that input is dropped.
  - Reset mid-stream discards the in-flight result.
- Boundary cases:
  - Negative zero (sign=1, magnitude 0): complement yields 0 and the flag is still 1.
  - Magnitude 2^(WIDTH-1) negated yields 2^(WIDTH-1) (self-complement). This is not flagged as an error.
  - Magnitude all-ones negated yields 1.
- Inputs are not registered; no X-propagation masking is required beyond reset.

Decomposition:
- Shared package adder_cu_pkg:
  - default WIDTH constant
  - opcode constants OP_ADD = 1'b0, OP_SUB = 1'b1
  - bit-index constants CF_A = 1, CF_B = 0 for the c vector
- One sub-module, twos_comp_cond:
  - purely combinational, parameterized by WIDTH
  - inputs: magnitude and enable; output: enable ? -mag : mag
  - instantiated twice, once for A and once for B.
- Control-flag logic and the output register live in adder_cu.

Test Plan:
- Exhaustive sign/op sweep: apply all 8 values of {A[32], B[32], a} with magnitudes A=5, B=3 -> one cycle later c matches the truth table. For example, {1,0,1} gives c=11, A_out=0xFFFFFFFB, B_out=0xFFFFFFFD.
- Plain add: A=+0x00000010, B=+0x00000020, a=0 -> c=00, A_out=0x10, B_out=0x20, out_valid=1 one cycle after in_valid.
- Subtract of positive: A=+7, B=+7, a=1 -> c=01, A_out=0x7, B_out=0xFFFFFFF9.
- Boundaries: negative zero, negative 0x80000000, negative 0xFFFFFFFF (all with a=0) -> A_out = 0x00000000, 0x80000000, 0x00000001 respectively, with c[1]=1 in each case.
- Reset behaviour:
  - rst=1 asserted together with in_valid=1 -> next cycle out_valid=0, A_out=B_out=0, c=00.
  - After rst deasserts, with in_valid=0 and no input, outputs stay 0.
- Hold and streaming:
  - back-to-back in_valid for 3 cycles with distinct operands -> 3 consecutive correct results, out_valid high for exactly those 3 cycles.
  - then in_valid=0 -> outputs hold the last values and out_valid=0.
